// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline register.
// Holds the occupancy state encoding and the bubble (nop) constant.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int NUM_CH_DEF = 5;
    localparam int DW_DEF     = 32;
    localparam int CNT_W_DEF  = 16;

    // Bubble payload bit; a bubble is this bit replicated (all-zero nop).
    localparam logic BUBBLE = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Counts pulses on inc and sticks at the all-ones value.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    // Advance on inc unless already at the ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE_STEP;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Two-entry skid-buffer pipeline register with flush, halt and a
// saturating counter of bubbles handed to a ready downstream stage.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DW     = DW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 halt,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [NUM_CH*DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NUM_CH*DW-1:0] m_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int PW = NUM_CH * DW;

    state_t          state_q;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            acc;
    logic            xfer;
    logic            bubble_inc;

    // Ready depends only on state and halt; held low while in reset.
    assign s_ready    = (state_q != TWO) && !halt && reset;
    assign m_valid    = (state_q != EMPTY);
    assign m_data     = m_valid ? main_q : {PW{BUBBLE}};
    assign occupancy  = state_q;
    assign acc        = s_valid && s_ready;
    assign xfer       = m_valid && m_ready;
    assign bubble_inc = m_ready && !m_valid;

    // Occupancy FSM and payload registers; flush beats accept/transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_q  <= s_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        main_q <= s_data;
                    end else if (acc) begin
                        skid_q  <= s_data;
                        state_q <= TWO;
                    end else if (xfer) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg with a queue-based reference model.
// Outputs are compared against the model on every falling edge.
module tb_elastic_pipe_reg;

    localparam int NUM_CH = 5;
    localparam int DW     = 32;
    localparam int CNT_W  = 4;
    localparam int PW     = NUM_CH * DW;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             halt;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [PW-1:0]    s_data;
    logic             m_valid;
    logic             m_ready;
    logic [PW-1:0]    m_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bubble_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] q[$];
    int            mcnt;

    elastic_pipe_reg #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_s_ready();
        return reset && !halt && (q.size() < 2);
    endfunction

    function automatic logic [PW-1:0] model_m_data();
        if (q.size() == 0) return '0;
        return q[0];
    endfunction

    // Reference model: a FIFO of at most two beats.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            mcnt = 0;
        end else begin
            logic acc_m;
            logic xfer_m;
            acc_m  = s_valid && model_s_ready();
            xfer_m = m_ready && (q.size() > 0);
            if (m_ready && q.size() == 0 && mcnt < CMAX) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (xfer_m) void'(q.pop_front());
                if (acc_m) q.push_back(s_data);
            end
        end
    end

    task automatic chk(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle compare against the model.
    always @(negedge clk) begin
        chk("m_valid", PW'(m_valid), PW'(q.size() > 0));
        chk("m_data", m_data, model_m_data());
        chk("occupancy", PW'(occupancy), PW'(q.size()));
        chk("s_ready", PW'(s_ready), PW'(model_s_ready()));
        chk("bubble_cnt", PW'(bubble_cnt), PW'(mcnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] ch1(input logic [DW-1:0] v);
        logic [PW-1:0] d;
        d = '0;
        d[DW +: DW] = v;
        return d;
    endfunction

    task automatic push2(input logic [PW-1:0] a, input logic [PW-1:0] b);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = a;
        step();
        s_data  = b;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        halt    = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        step();
        step();
        chk("rst_m_valid", PW'(m_valid), '0);
        chk("rst_s_ready", PW'(s_ready), '0);
        chk("rst_occ", PW'(occupancy), '0);
        chk("rst_cnt", PW'(bubble_cnt), '0);
        reset = 1'b1;
        step();

        // First beat: latency one, channel 1 payload.
        s_valid = 1'b1;
        s_data  = ch1(32'h24080005);
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lat_m_valid", PW'(m_valid), PW'(1));
        chk("lat_ch1", PW'(m_data[DW +: DW]), PW'(32'h24080005));
        chk("lat_occ", PW'(occupancy), PW'(1));
        step();

        // Fill to two, hold off C, then drain in order.
        push2(PW'(1), PW'(2));
        chk("full_occ", PW'(occupancy), PW'(2));
        chk("full_s_ready", PW'(s_ready), '0);
        s_valid = 1'b1;
        s_data  = PW'(3);
        step();
        chk("held_occ", PW'(occupancy), PW'(2));
        chk("out_A", m_data, PW'(1));
        m_ready = 1'b1;
        step();
        chk("out_B", m_data, PW'(2));
        step();
        s_valid = 1'b0;
        chk("out_C", m_data, PW'(3));
        step();
        chk("drained_valid", PW'(m_valid), '0);

        // Halt does not block draining.
        push2(PW'(32'h11), PW'(32'h22));
        halt    = 1'b1;
        m_ready = 1'b1;
        step();
        chk("halt_s_ready1", PW'(s_ready), '0);
        chk("halt_data", m_data, PW'(32'h22));
        step();
        chk("halt_occ", PW'(occupancy), '0);
        chk("halt_m_data", m_data, '0);
        chk("halt_s_ready2", PW'(s_ready), '0);
        halt = 1'b0;

        // Flush beats a simultaneous accept and transfer.
        push2(PW'(32'h33), PW'(32'h44));
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = PW'(32'h55);
        m_ready = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_occ", PW'(occupancy), '0);
        chk("flush_valid", PW'(m_valid), '0);

        // Asynchronous reset mid-cycle.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = PW'(32'h66);
        step();
        s_valid = 1'b0;
        chk("pre_arst_occ", PW'(occupancy), PW'(1));
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", PW'(m_valid), '0);
        chk("arst_occ", PW'(occupancy), '0);
        step();
        reset = 1'b1;

        // Bubble counter saturates, survives flush, cleared by reset.
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", PW'(bubble_cnt), PW'(15));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_cnt", PW'(bubble_cnt), PW'(15));
        #1;
        reset = 1'b0;
        #1;
        chk("rst_cnt2", PW'(bubble_cnt), '0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of payload channels (pc, instr, extImm, rs, rt).
REQ-002 SHALL have parameter DW, default 32, width of each channel in bits.
REQ-003 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port halt  input  1  hazard stall; when 1, no new beat is accepted.
REQ-007 SHALL have port flush  input  1  discards all held beats on the next edge.
REQ-008 SHALL have port s_valid  input  1  upstream beat present.
REQ-009 SHALL have port s_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port s_data  input  NUM_CH*DW  upstream payload, channel k at bits [k*DW +: DW].
REQ-011 SHALL have port m_valid  output  1  downstream beat present.
REQ-012 SHALL have port m_ready  input  1  downstream consumes this cycle.
REQ-013 SHALL have port m_data  output  NUM_CH*DW  downstream payload.
REQ-014 SHALL have port occupancy  output  2  held beats (0..2).
REQ-015 SHALL have port bubble_cnt  output  CNT_W  saturating count of bubbles issued.

Function
REQ-016 SHALL be a 2-entry skid buffer: main register (drives m_data) plus skid register.
REQ-017 SHALL implement states EMPTY (0 held), ONE (main full), TWO (main and skid full); occupancy equals 0/1/2 respectively.
REQ-018 SHALL drive s_ready = (state != TWO) && !halt, combinationally from state and halt only (no s_valid/m_ready path).
REQ-019 SHALL accept a beat when s_valid && s_ready, and transfer a beat when m_valid && m_ready.
REQ-020 SHALL drive m_valid = (state != EMPTY).
REQ-021 EMPTY: accept -> ONE, beat in main; m_valid rises one cycle after acceptance (latency 1); m_ready ignored.
REQ-022 ONE: accept+transfer -> ONE with new beat in main; accept only -> TWO with beat in skid; transfer only -> EMPTY.
REQ-023 TWO: transfer -> ONE with skid contents moved to main; no accept possible.
REQ-024 SHALL preserve beat order; no beat is duplicated or lost except by flush.
REQ-025 SHALL drive m_data to all-zero (bubble, instr = nop 0x00000000) whenever m_valid = 0.
REQ-026 flush = 1 SHALL force state EMPTY on the next edge, overriding any simultaneous accept or transfer; an accepted beat in that cycle is discarded.
REQ-027 halt SHALL NOT affect the output side; held beats still drain to downstream while halt = 1.
REQ-028 bubble_cnt SHALL increment by 1 on each edge where m_ready = 1 and m_valid = 0, and hold at 2^CNT_W-1 (saturate, no wrap).
REQ-029 flush SHALL NOT clear bubble_cnt.

Reset
REQ-030 While reset = 0, state SHALL be EMPTY, both registers zero, bubble_cnt zero, asynchronously.
REQ-031 During reset, outputs SHALL be m_valid=0, m_data=0, occupancy=0, bubble_cnt=0, s_ready=!halt... forced 0 (s_ready=0 while reset asserted).
REQ-032 Reset asserted mid-operation SHALL drop all held beats; first accept possible on the first edge after release.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the state enum (EMPTY/ONE/TWO), default NUM_CH/DW/CNT_W, and the bubble constant (zero).
REQ-034 A single sub-module sat_counter (parameter width, inc input, async active-low reset) SHALL implement bubble_cnt; everything else is flat.

Verification
REQ-035 Reset then s_valid=1, s_data ch1=0x24080005, m_ready=1 -> m_valid=1 next cycle with ch1=0x24080005, occupancy=1.
REQ-036 m_ready=0, push beats A=0x1, B=0x2 -> occupancy=2, s_ready=0; third beat C held off; m_ready=1 -> outputs A, B, C in order.
REQ-037 halt=1 with occupancy=2, m_ready=1 -> two beats drain, s_ready stays 0, occupancy reaches 0, m_data=0.
REQ-038 occupancy=2, flush=1 together with s_valid=1 and m_ready=1 -> next cycle occupancy=0, m_valid=0, no beat delivered.
REQ-039 CNT_W=4, empty, m_ready=1 for 20 cycles -> bubble_cnt reaches 15 and holds; flush leaves 15; reset clears to 0.
REQ-040 reset=0 asserted between edges while occupancy=1 -> m_valid=0 immediately, before next clock edge.
